ft245_tx_fifo: RTL and testbench

//  Byte FIFO and drain sequencer sitting directly upstream of the FT245RL interface block.

---
 rtl/ft245_tx_fifo.sv | 119 +++++++++++
 tb/tb_ft245_tx_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_tx_fifo.sv
// Byte FIFO feeding the FT245RL interface: pops one byte per TXEN pulse and waits for TX_DONE.
// A hung transfer is abandoned after TIMEOUT_CYC cycles in WAIT and reported on TX_ERR.
module ft245_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [7:0]        WR_DATA,
    output logic              FULL,
    output logic              EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              TXEN,
    output logic [7:0]        TX_DATA,
    input  logic              TX_VALID,
    input  logic              TX_DONE,
    output logic              TX_ERR
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              launch;
    logic              timeout;

    // A push is judged against the registered FULL, so a same-cycle pop cannot rescue it.
    assign push       = WR_EN && !FULL;
    assign count_next = COUNT + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(launch);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!EMPTY && !TX_VALID) begin
                    launch     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // TX_DONE takes priority over a timeout landing on the same cycle.
                if (TX_DONE) begin
                    state_next = S_IDLE;
                end else if (TIMEOUT_CYC != 0 && timer == TMR_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
            OVERFLOW <= 1'b0;
            TXEN     <= 1'b0;
            TX_DATA  <= 8'h00;
            TX_ERR   <= 1'b0;
            timer    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (launch) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                TX_DATA <= mem[rd_ptr];
            end
            COUNT    <= count_next;
            FULL     <= (count_next == CNT_FULL);
            EMPTY    <= (count_next == '0);
            OVERFLOW <= WR_EN && FULL;
            TXEN     <= launch;
            TX_ERR   <= timeout;
            if (launch) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft245_tx_fifo.sv
// Testbench for ft245_tx_fifo: directed scenarios plus a randomized run against a queue-based model.
module tb_ft245_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WR_EN;
    logic [7:0]    WR_DATA;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic          TXEN;
    logic [7:0]    TX_DATA;
    logic          TX_VALID;
    logic          TX_DONE;
    logic          TX_ERR;

    ft245_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .TXEN(TXEN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_DONE(TX_DONE),
        .TX_ERR(TX_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;
    int done_dly = 0;

    // Observations, sampled mid-cycle.
    logic [7:0] obs_q[$];
    int txen_cnt = 0, err_cnt = 0, ovf_cnt = 0, cyc = 0, txen_cyc = 0, err_cyc = 0;

    always @(negedge CLK) begin
        cyc++;
        if (TXEN === 1'b1) begin
            obs_q.push_back(TX_DATA);
            txen_cnt++;
            txen_cyc = cyc;
        end
        if (TX_ERR === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (OVERFLOW === 1'b1) ovf_cnt++;
    end

    // FT245RL stand-in: TX_DONE done_dly cycles after a TXEN pulse (0 = never).
    initial begin
        TX_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (TXEN === 1'b1 && done_dly > 0) begin
                repeat (done_dly - 1) @(negedge CLK);
                TX_DONE = 1'b1;
                @(negedge CLK);
                TX_DONE = 1'b0;
            end
        end
    end

    // Reference: byte queue plus "one transfer outstanding" bookkeeping.
    logic [7:0] mq[$];
    bit         m_busy = 0;
    int         m_wait = 0;
    logic       m_txen = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge CLK) begin
        int pre;
        bit go;
        if (RST) begin
            mq.delete();
            m_busy = 0; m_wait = 0;
            m_txen = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
        end else begin
            pre   = mq.size();
            m_ovf = WR_EN && (pre == DEPTH);
            m_err = 1'b0;
            go    = !m_busy && (pre > 0) && !TX_VALID;
            if (m_busy) begin
                m_wait++;
                if (TX_DONE) m_busy = 0;
                else if (m_wait == TO) begin
                    m_busy = 0;
                    m_err  = 1'b1;
                end
            end
            m_txen = go;
            if (go) begin
                m_data = mq.pop_front();
                m_busy = 1;
                m_wait = 0;
            end
            if (WR_EN && pre < DEPTH) mq.push_back(WR_DATA);
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        vectors += 7;
        if (TXEN !== 1'b0)     begin errors++; $display("FAIL reset_txen got=%b exp=0", TXEN); end
        if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", TX_DATA); end
        if (COUNT !== '0)      begin errors++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        if (EMPTY !== 1'b1)    begin errors++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
        if (FULL !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", FULL); end
        if (TX_ERR !== 1'b0)   begin errors++; $display("FAIL reset_txerr got=%b exp=0", TX_ERR); end
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int b = txen_cnt;
        int e = err_cnt;
        done_dly = 5;
        WR_EN = 1'b1; WR_DATA = 8'h55;
        tick();
        WR_EN = 1'b0;
        vectors += 2;
        if (COUNT !== 5'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", COUNT); end
        if (TXEN !== 1'b0)  begin errors++; $display("FAIL single_early_txen got=%b exp=0", TXEN); end
        tick();
        vectors += 3;
        if (TXEN !== 1'b1)     begin errors++; $display("FAIL single_txen got=%b exp=1", TXEN); end
        if (TX_DATA !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", TX_DATA); end
        if (COUNT !== 5'd0)    begin errors++; $display("FAIL single_count0 got=%0d exp=0", COUNT); end
        tick();
        vectors++;
        if (TXEN !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", TXEN); end
        repeat (12) tick();
        vectors += 3;
        if (txen_cnt - b != 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", txen_cnt - b); end
        if (err_cnt != e)      begin errors++; $display("FAIL single_txerr got=%0d exp=0", err_cnt - e); end
        if (TX_DATA !== 8'h55) begin errors++; $display("FAIL single_data_hold got=%h exp=55", TX_DATA); end
    endtask

    task automatic test_burst();
        int b  = txen_cnt;
        int ob = obs_q.size();
        done_dly = 6;
        for (int i = 1; i <= 4; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            tick();
        end
        WR_EN = 1'b0;
        for (int i = 0; i < 100 && (txen_cnt - b) < 4; i++) tick();
        repeat (20) tick();
        vectors++;
        if (txen_cnt - b != 4) begin errors++; $display("FAIL burst_pulses got=%0d exp=4", txen_cnt - b); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs_q.size() <= ob + i) begin
                errors++; $display("FAIL burst_order idx=%0d got=none exp=%0d", i, i + 1);
            end else if (obs_q[ob + i] !== 8'(i + 1)) begin
                errors++; $display("FAIL burst_order idx=%0d got=%h exp=%h", i, obs_q[ob + i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] pushed[$];
        int b  = txen_cnt;
        int ob = obs_q.size();
        int ov = ovf_cnt;
        done_dly = 3;
        TX_VALID = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'($urandom);
            pushed.push_back(WR_DATA);
            tick();
        end
        WR_EN = 1'b0;
        tick();
        vectors += 3;
        if (FULL !== 1'b1)           begin errors++; $display("FAIL full_flag got=%b exp=1", FULL); end
        if (COUNT !== 5'(DEPTH))     begin errors++; $display("FAIL full_count got=%0d exp=%0d", COUNT, DEPTH); end
        if (ovf_cnt - ov != 1)       begin errors++; $display("FAIL full_overflow got=%0d exp=1", ovf_cnt - ov); end
        TX_VALID = 1'b0;
        for (int i = 0; i < 200 && (txen_cnt - b) < DEPTH; i++) begin
            tick();
            vectors++;
            if ({TXEN, TX_DATA, COUNT, FULL, EMPTY} !== {m_txen, m_data, 5'(mq.size()),
                    mq.size() == DEPTH, mq.size() == 0}) begin
                errors++;
                $display("FAIL drain_model cyc=%0d got txen=%b data=%h cnt=%0d exp txen=%b data=%h cnt=%0d",
                         cyc, TXEN, TX_DATA, COUNT, m_txen, m_data, mq.size());
            end
        end
        repeat (10) tick();
        vectors++;
        if (txen_cnt - b != DEPTH) begin errors++; $display("FAIL full_drained got=%0d exp=%0d", txen_cnt - b, DEPTH); end
        for (int i = 0; i < DEPTH && obs_q.size() > ob + i; i++) begin
            vectors++;
            if (obs_q[ob + i] !== pushed[i]) begin
                errors++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, obs_q[ob + i], pushed[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int b = txen_cnt;
        int e = err_cnt;
        logic [7:0] nb;
        done_dly = 0;
        WR_EN = 1'b1; WR_DATA = 8'hA5;
        tick();
        WR_EN = 1'b0;
        for (int i = 0; i < 20 && txen_cnt == b; i++) tick();
        for (int i = 0; i < 20 && err_cnt == e; i++) tick();
        vectors += 3;
        if (txen_cnt - b != 1)         begin errors++; $display("FAIL tmo_launch got=%0d exp=1", txen_cnt - b); end
        if (obs_q[$] !== 8'hA5)        begin errors++; $display("FAIL tmo_data got=%h exp=a5", obs_q[$]); end
        if (err_cnt - e != 1 || err_cyc - txen_cyc != TO) begin
            errors++; $display("FAIL tmo_delay got errs=%0d gap=%0d exp errs=1 gap=%0d", err_cnt - e, err_cyc - txen_cyc, TO);
        end
        done_dly = 4;
        nb = 8'($urandom);
        WR_EN = 1'b1; WR_DATA = nb;
        tick();
        WR_EN = 1'b0;
        repeat (15) tick();
        vectors += 3;
        if (txen_cnt - b != 2) begin errors++; $display("FAIL tmo_next_launch got=%0d exp=2", txen_cnt - b); end
        if (obs_q[$] !== nb)   begin errors++; $display("FAIL tmo_next_data got=%h exp=%h", obs_q[$], nb); end
        if (err_cnt - e != 1)  begin errors++; $display("FAIL tmo_extra_err got=%0d exp=1", err_cnt - e); end
    endtask

    task automatic test_simul_reset();
        int b;
        int e;
        done_dly = 0;
        TX_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'($urandom);
            tick();
        end
        WR_EN = 1'b0;
        tick();
        vectors++;
        if (COUNT !== 5'd3) begin errors++; $display("FAIL simul_pre_count got=%0d exp=3", COUNT); end
        TX_VALID = 1'b0;
        WR_EN = 1'b1; WR_DATA = 8'($urandom);
        tick();
        WR_EN = 1'b0;
        vectors += 2;
        if (COUNT !== 5'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", COUNT); end
        if (TXEN !== 1'b1)  begin errors++; $display("FAIL simul_txen got=%b exp=1", TXEN); end
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vectors += 4;
        if (COUNT !== 5'd0)  begin errors++; $display("FAIL rst_wait_count got=%0d exp=0", COUNT); end
        if (TXEN !== 1'b0)   begin errors++; $display("FAIL rst_wait_txen got=%b exp=0", TXEN); end
        if (TX_ERR !== 1'b0) begin errors++; $display("FAIL rst_wait_txerr got=%b exp=0", TX_ERR); end
        if (EMPTY !== 1'b1)  begin errors++; $display("FAIL rst_wait_empty got=%b exp=1", EMPTY); end
        b = txen_cnt;
        e = err_cnt;
        repeat (TO + 6) tick();
        vectors++;
        if (err_cnt != e || txen_cnt != b) begin
            errors++; $display("FAIL rst_wait_quiet got errs=%0d txens=%0d exp 0 0", err_cnt - e, txen_cnt - b);
        end
    endtask

    task automatic test_random();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 600; i++) begin
            WR_EN    = ($urandom_range(0, 99) < 45);
            WR_DATA  = 8'($urandom);
            TX_VALID = ($urandom_range(0, 99) < 20);
            done_dly = $urandom_range(1, 10);
            tick();
            vectors++;
            if ({TXEN, TX_DATA, COUNT, FULL, EMPTY, OVERFLOW, TX_ERR} !==
                {m_txen, m_data, 5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_err}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got txen=%b data=%h cnt=%0d ovf=%b err=%b exp txen=%b data=%h cnt=%0d ovf=%b err=%b",
                         cyc, TXEN, TX_DATA, COUNT, OVERFLOW, TX_ERR, m_txen, m_data, mq.size(), m_ovf, m_err);
            end
        end
        WR_EN = 1'b0;
        TX_VALID = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; WR_EN = 1'b0; WR_DATA = 8'h00; TX_VALID = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_timeout();
        test_simul_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
